// File: rtl/btn_mmio_rx.sv
// rtl/btn_mmio_rx.sv - button synchronizer/debouncer with MMIO level, event, count and mask registers
module btn_mmio_rx #(
    parameter int          NUM_BTNS        = 5,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [11:0] BASE_ADDR       = 12'd1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wEn,
    input  logic [11:0]         addr,
    input  logic [31:0]         dataIn,
    output logic [31:0]         dataOut,
    output logic                hit,
    input  logic [NUM_BTNS-1:0] btn,
    output logic                irq
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTNS-1:0] sync1;
    logic [NUM_BTNS-1:0] sync2;
    logic [NUM_BTNS-1:0] deb;
    logic [NUM_BTNS-1:0] deb_d;
    logic [NUM_BTNS-1:0] evt;
    logic [NUM_BTNS-1:0] mask;
    logic [NUM_BTNS-1:0] press;
    logic [CW-1:0]       dcnt [NUM_BTNS];
    logic [15:0]         cnt;

    logic [11:0] offs;
    logic [1:0]  sel;
    logic        wr_evt;
    logic        wr_cnt;
    logic        wr_mask;
    logic        unused_din;

    // Offset decode keeps the window compare free of carry-out corner cases.
    assign offs    = addr - BASE_ADDR;
    assign hit     = (offs[11:2] == 10'd0);
    assign sel     = offs[1:0];
    assign wr_evt  = wEn && hit && (sel == 2'd1);
    assign wr_cnt  = wEn && hit && (sel == 2'd2);
    assign wr_mask = wEn && hit && (sel == 2'd3);

    assign press      = deb & ~deb_d;
    assign irq        = |(evt & mask);
    assign unused_din = &{1'b0, dataIn[31:16]};

    always_comb begin
        dataOut = 32'd0;
        if (hit) begin
            case (sel)
                2'd0:    dataOut[NUM_BTNS-1:0] = deb;
                2'd1:    dataOut[NUM_BTNS-1:0] = evt;
                2'd2:    dataOut[15:0]         = cnt;
                default: dataOut[NUM_BTNS-1:0] = mask;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            evt   <= '0;
            mask  <= '0;
            cnt   <= 16'd0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == CNT_MAX) begin
                    deb[i]  <= ~deb[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CW'(1);
                end
            end
            // A press landing with a W1C clear keeps its flag.
            evt <= (evt & ~(wr_evt ? dataIn[NUM_BTNS-1:0] : '0)) | press;
            if (wr_cnt) begin
                cnt <= dataIn[15:0];
            end else if (press[0]) begin
                cnt <= cnt + 16'd1;
            end
            if (wr_mask) begin
                mask <= dataIn[NUM_BTNS-1:0];
            end
        end
    end

endmodule

// File: tb/tb_btn_mmio_rx.sv
// tb/tb_btn_mmio_rx.sv - scoreboard bench for btn_mmio_rx
module tb_btn_mmio_rx;

    localparam logic [11:0] BASE   = 12'd1000;
    localparam logic [11:0] A_LVL  = BASE;
    localparam logic [11:0] A_EVT  = BASE + 12'd1;
    localparam logic [11:0] A_CNT  = BASE + 12'd2;
    localparam logic [11:0] A_MSK  = BASE + 12'd3;

    logic        clk;
    logic        rst_n;
    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        hit;
    logic [4:0]  btn;
    logic        irq;

    int    q_kind [$];
    logic [31:0] q_val [$];
    string q_name [$];
    int    passed;
    int    total;

    btn_mmio_rx #(
        .NUM_BTNS       (5),
        .DEBOUNCE_CYCLES(4),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wEn    (wEn),
        .addr   (addr),
        .dataIn (dataIn),
        .dataOut(dataOut),
        .hit    (hit),
        .btn    (btn),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: everything queued during a cycle is checked at its falling edge.
    always @(negedge clk) begin
        int          k;
        logic [31:0] v;
        logic [31:0] act;
        string       n;
        while (q_kind.size() > 0) begin
            k = q_kind.pop_front();
            v = q_val.pop_front();
            n = q_name.pop_front();
            case (k)
                0:       act = dataOut;
                1:       act = {31'd0, irq};
                default: act = {31'd0, hit};
            endcase
            total++;
            if (act === v) passed++;
            else $display("FAIL %s: got %h expected %h", n, act, v);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push(input int k, input logic [31:0] v, input string n);
        q_kind.push_back(k);
        q_val.push_back(v);
        q_name.push_back(n);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        wEn = 1'b0;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic exp_hit, input string n);
        addr = a;
        wEn  = 1'b0;
        push(0, exp, n);
        push(2, {31'd0, exp_hit}, {n, "_hit"});
        cyc();
    endtask

    task automatic chk_irq(input logic exp, input string n);
        push(1, {31'd0, exp}, n);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr   = a;
        dataIn = d;
        wEn    = 1'b1;
        cyc();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        wEn    = 1'b0;
        addr   = A_LVL;
        dataIn = 32'd0;
        btn    = 5'b11111;
        cycn(2);

        // Reset state, pins all high
        chk_irq(1'b0, "rst_irq");
        rd(A_LVL, 32'd0, 1'b1, "rst_level");
        rd(A_EVT, 32'd0, 1'b1, "rst_event");
        rd(A_CNT, 32'd0, 1'b1, "rst_count");
        rd(A_MSK, 32'd0, 1'b1, "rst_mask");
        rst_n = 1'b1;
        cycn(5);
        rd(A_LVL, 32'd0, 1'b1, "rel_level_early");
        rd(A_LVL, 32'h1f, 1'b1, "rel_level_on_time");
        rd(A_EVT, 32'h1f, 1'b1, "rel_event_all");
        rd(A_CNT, 32'd1, 1'b1, "rel_count");
        btn = 5'b00000;
        cycn(8);
        rd(A_LVL, 32'd0, 1'b1, "release_level");
        rd(A_EVT, 32'h1f, 1'b1, "release_no_event");
        wr(A_EVT, 32'hffff_ffff);
        rd(A_EVT, 32'd0, 1'b1, "w1c_all");
        wr(A_CNT, 32'd0);
        rd(A_CNT, 32'd0, 1'b1, "count_load0");

        // Glitch of 3 cycles
        btn[0] = 1'b1;
        cycn(3);
        btn[0] = 1'b0;
        cycn(8);
        rd(A_LVL, 32'd0, 1'b1, "glitch_level");
        rd(A_EVT, 32'd0, 1'b1, "glitch_event");

        // Clean hold: LEVEL rises after exactly 6 edges
        btn[0] = 1'b1;
        cycn(5);
        rd(A_LVL, 32'd0, 1'b1, "hold_level_5");
        rd(A_LVL, 32'd1, 1'b1, "hold_level_6");
        rd(A_EVT, 32'd1, 1'b1, "hold_event");
        rd(A_CNT, 32'd1, 1'b1, "hold_count");
        btn[0] = 1'b0;
        cycn(8);
        rd(A_EVT, 32'd1, 1'b1, "hold_release_event");
        rd(A_CNT, 32'd1, 1'b1, "hold_release_count");

        // W1C and interrupt
        wr(A_EVT, 32'd1);
        rd(A_EVT, 32'd0, 1'b1, "w1c_bit0");
        wr(A_MSK, 32'd1);
        chk_irq(1'b0, "irq_masked_idle");
        rd(A_MSK, 32'd1, 1'b1, "mask_rd");
        btn[0] = 1'b1;
        cycn(6);
        chk_irq(1'b0, "irq_press_cycle");
        rd(A_LVL, 32'd1, 1'b1, "irq_level");
        chk_irq(1'b1, "irq_set");
        wr(A_EVT, 32'd1);
        chk_irq(1'b0, "irq_cleared");
        rd(A_EVT, 32'd0, 1'b1, "irq_event_cleared");
        btn[0] = 1'b0;
        cycn(8);

        // Clear collides with a new press: set wins
        btn[0] = 1'b1;
        cycn(6);
        wr(A_EVT, 32'd1);
        chk_irq(1'b1, "collide_irq");
        rd(A_EVT, 32'd1, 1'b1, "collide_event");
        rd(A_CNT, 32'd3, 1'b1, "collide_count");
        btn[0] = 1'b0;
        cycn(8);
        wr(A_EVT, 32'h1f);

        // Counter wrap
        wr(A_CNT, 32'h0000_ffff);
        rd(A_CNT, 32'h0000_ffff, 1'b1, "count_ffff");
        btn[0] = 1'b1;
        cycn(7);
        rd(A_CNT, 32'd0, 1'b1, "count_wrap");
        btn[0] = 1'b0;
        cycn(8);
        wr(A_EVT, 32'd1);

        // COUNT write on the press cycle wins, event still sets
        btn[0] = 1'b1;
        cycn(6);
        wr(A_CNT, 32'habcd_0010);
        rd(A_CNT, 32'h0000_0010, 1'b1, "count_load_collide");
        rd(A_EVT, 32'd1, 1'b1, "count_collide_event");
        btn[0] = 1'b0;
        cycn(8);
        wr(A_EVT, 32'h1f);

        // Two buttons together
        btn = 5'b10100;
        cycn(7);
        rd(A_EVT, 32'h14, 1'b1, "multi_event");
        rd(A_CNT, 32'h10, 1'b1, "multi_count");
        chk_irq(1'b0, "multi_irq_masked");
        wr(A_MSK, 32'hffff_ffe4);
        chk_irq(1'b1, "multi_irq_bit2");
        rd(A_MSK, 32'h4, 1'b1, "mask_width");
        wr(A_EVT, 32'hffff_ffe4);
        chk_irq(1'b0, "w1c_partial_irq");
        rd(A_EVT, 32'h10, 1'b1, "w1c_partial");
        btn = 5'b00000;
        cycn(8);

        // Address decode
        rd(BASE + 12'd4, 32'd0, 1'b0, "unmapped_hi");
        rd(BASE - 12'd1, 32'd0, 1'b0, "unmapped_lo");
        wr(BASE + 12'd4, 32'hffff_ffff);
        rd(A_EVT, 32'h10, 1'b1, "ignored_wr_event");
        rd(A_CNT, 32'h10, 1'b1, "ignored_wr_count");
        rd(A_MSK, 32'h4, 1'b1, "ignored_wr_mask");

        // Reset in the middle of a debounce window
        btn = 5'b00010;
        cycn(2);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        rd(A_EVT, 32'd0, 1'b1, "mid_rst_event");
        rd(A_MSK, 32'd0, 1'b1, "mid_rst_mask");
        rd(A_CNT, 32'd0, 1'b1, "mid_rst_count");
        cycn(2);
        rd(A_LVL, 32'd0, 1'b1, "mid_rst_level_5");
        rd(A_LVL, 32'd2, 1'b1, "mid_rst_level_6");
        rd(A_EVT, 32'd2, 1'b1, "mid_rst_event_btn1");
        rd(A_CNT, 32'd0, 1'b1, "mid_rst_count_btn1");

        cycn(2);
        total++;
        if (q_kind.size() == 0) passed++;
        else $display("FAIL drain: got %0d expected 0", q_kind.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
